// File: rtl/bitbrick_seq_mac_ctrl_if.sv
// Operand/result handshake bundle for the sequential bitbrick multiplier.
// The master drives operands and result ready; the slave is the multiplier.
interface bitbrick_seq_mac_ctrl_if #(
    parameter int MAX_BITS = 8,
    parameter int OUT_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [MAX_BITS-1:0] a;
    logic [MAX_BITS-1:0] w;
    logic [1:0]          prec;
    logic                is_signed;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] p;
    logic                busy;

    modport master (
        output in_valid, a, w, prec, is_signed, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, w, prec, is_signed, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/bitbrick_seq_mac_ctrl.sv
// Sequential 2/4/8-bit signed/unsigned multiplier built from one 2x2 unsigned
// bitbrick per cycle; operands are reduced to sign + magnitude up front.
module bitbrick_seq_mac_ctrl #(
    parameter int MAX_BITS = 8,
    parameter int OUT_BITS = 16
) (
    input logic clk,
    input logic rst,
    bitbrick_seq_mac_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [MAX_BITS-1:0] mag_a, mag_w;
    logic                neg;
    logic [1:0]          k_last;
    logic [1:0]          i, j;
    logic [OUT_BITS-1:0] acc;

    logic [MAX_BITS-1:0] width_mask, sign_sel;
    logic [1:0]          k_in;
    logic [MAX_BITS-1:0] trunc_a, trunc_w, mag_a_in, mag_w_in;
    logic                sign_a, sign_w;
    logic [3:0]          prod;
    logic [3:0]          shamt;
    logic [OUT_BITS-1:0] acc_next;
    logic                last_chunk;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        width_mask = '1;
        sign_sel   = 8'h80;
        k_in       = 2'd3;
        case (bus.prec)
            2'd0: begin width_mask = 8'h03; sign_sel = 8'h02; k_in = 2'd0; end
            2'd1: begin width_mask = 8'h0F; sign_sel = 8'h08; k_in = 2'd1; end
            default: ;
        endcase

        // Upper bits beyond the selected width are junk and dropped here.
        trunc_a  = bus.a & width_mask;
        trunc_w  = bus.w & width_mask;
        sign_a   = bus.is_signed && ((trunc_a & sign_sel) != '0);
        sign_w   = bus.is_signed && ((trunc_w & sign_sel) != '0);
        mag_a_in = sign_a ? ((~trunc_a + 8'd1) & width_mask) : trunc_a;
        mag_w_in = sign_w ? ((~trunc_w + 8'd1) & width_mask) : trunc_w;

        prod       = {2'b00, mag_a[{i, 1'b0} +: 2]} * {2'b00, mag_w[{j, 1'b0} +: 2]};
        shamt      = {({1'b0, i} + {1'b0, j}), 1'b0};
        acc_next   = acc + ({12'd0, prod} << shamt);
        last_chunk = (i == k_last) && (j == k_last);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
        if (rst) begin
            state         <= IDLE;
            mag_a         <= '0;
            mag_w         <= '0;
            neg           <= 1'b0;
            k_last        <= '0;
            i             <= '0;
            j             <= '0;
            acc           <= '0;
            bus.p         <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_a        <= mag_a_in;
                        mag_w        <= mag_w_in;
                        neg          <= sign_a ^ sign_w;
                        k_last       <= k_in;
                        i            <= '0;
                        j            <= '0;
                        acc          <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_chunk) begin
                        bus.p         <= neg ? (~acc_next + 16'd1) : acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (j == k_last) begin
                        j <= '0;
                        i <= i + 2'd1;
                    end else begin
                        j <= j + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bitbrick_seq_mac_ctrl.md
Name: bitbrick_seq_mac_ctrl

Overview:
Iterative multiplier controller that time-multiplexes a single 2x2-bit unsigned bitbrick product per cycle to compute a full 2/4/8-bit signed or unsigned product. Sits between the PE operand fetch and the accumulator stage of the sparse DNN array. Trades throughput for area when only one bitbrick slice is available. Uses valid/ready handshakes on both the operand and result sides.

Parameters:
- MAX_BITS, 8, maximum operand width. Must be 8 for this revision.
- OUT_BITS, 16, result width (2*MAX_BITS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  8  activation operand; bits above the selected precision are ignored
- w  in  8  weight operand; bits above the selected precision are ignored
- prec  in  2  precision: 0 = 2-bit, 1 = 4-bit, 2 = 8-bit, 3 = treated as 8-bit
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- p  out  16  product, sign- or zero-extended to 16 bits
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Decided interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, p=0, busy=0, state=IDLE. All internal counters and the accumulator are cleared.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch prec and is_signed, and truncate a and w to the selected width B (2, 4 or 8).
  - If signed: sign bit = MSB of each truncated operand. Store magnitude = abs(operand) as an unsigned B-bit value (-2^(B-1) gives magnitude 2^(B-1), which fits). Store neg = sign_a XOR sign_w.
  - If unsigned: neg=0 and magnitude = operand.
  - Clear the accumulator, set chunk indices i=j=0, go to CALC.
- CALC: one chunk product per cycle.
  - prod = mag_a[2i+1:2i] * mag_w[2j+1:2j] (unsigned 4-bit, exact; bitbrick unsigned mode).
  - acc += prod << (2*(i+j)).
  - The accumulator is 16 bits unsigned and cannot overflow.
  - Iterate j inner, i outer, over K = B/2 chunks each, for N = K*K cycles: 1, 4 or 16.
  - On the last chunk, write p = neg ? -(acc_final) : acc_final. Two's-complement negation in 16 bits gives the correct sign extension; an unsigned result is zero-extended. Then go to DONE.
- DONE: out_valid=1 and p is held stable. in_ready=0.
  - On out_ready, set out_valid=0 next cycle and return to IDLE.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency: operand handshake in cycle t gives out_valid=1 in cycle t+N+1.
  - Minimum initiation interval is N+2 cycles with out_ready held high.
- in_ready is 0 in CALC and DONE. in_valid asserted then is ignored and is not queued.
- Operand inputs, prec and is_signed are sampled only at the handshake; later changes have no effect.
- p holds its last value in IDLE. out_valid is the only qualifier.
- Zero operand: still takes N cycles, result 0. Negative zero cannot occur.
- Reset asserted in any state, including mid-CALC: next cycle returns to IDLE with reset values. The partial result is discarded and out_valid is never asserted for it.
- busy = (state != IDLE).

Test Plan:
- 2-bit unsigned: a=3, w=3, prec=0, is_signed=0 -> p=0x0009, out_valid exactly 2 cycles after the handshake (N=1).
- 8-bit unsigned: a=0xFF, w=0xFF, prec=2 -> p=0xFE01 (65025) after 16 CALC cycles; busy high for 17 cycles with out_ready=1.
- 8-bit signed extremes:
  - a=0x80, w=0x80 -> p=0x4000 (16384).
  - a=0x80, w=0x7F -> p=0xC080 (-16256).
- 4-bit signed with junk upper bits: a=0xF8 (-8), w=0xA7 (7), prec=1, is_signed=1 -> p=0xFFC8 (-56), result after 4 CALC cycles. 2-bit signed a=2, w=2 -> p=0x0004.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> p and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one result transfer, then in_ready=1 next cycle.
- Reset mid-operation: assert rst at CALC cycle 7 of an 8-bit op -> next cycle out_valid=0, p=0, in_ready=1, busy=0. A following 3*5 unsigned op returns 15.
